eth_tx_framer: RTL and testbench
================================

Name: eth_tx_framer

Overview:
- Downstream stage of the Ethernet packager's header generator.
- Consumes the bit-ordered dibit stream (header dibits followed by payload dibits) and emits a complete RMII transmit frame: preamble/SFD, the delayed input data, zero padding to minimum length, CRC-32 FCS, then the inter-frame gap.
- Output feeds the RMII TX pins (TXEN = axiov, TXD = axiod).

Parameters:
- MIN_FRAME_DIBITS, 240, minimum data+pad length in dibits, excluding FCS (60 bytes); 0 disables padding.
- MAX_FRAME_DIBITS, 6056, maximum accepted input dibits (1514 bytes); excess input is dropped.
- IFG_DIBITS, 48, inter-frame gap length in dibits (12 bytes).

Ports:
- clk  input  1  system clock (RMII 50 MHz, one dibit per cycle).
- rst  input  1  asynchronous reset, active-low (asserted when 0).
- axiiv  input  1  input dibit valid; a frame is one contiguous high run.
- axiid  input  2  input dibit; bit 0 is the earlier wire bit.
- axiov  output  1  output dibit valid (TXEN).
- axiod  output  2  output dibit (TXD); bit 0 is the earlier wire bit.
- busy  output  1  high from frame start through the end of the IFG.
- drop  output  1  one-cycle pulse for each cycle an input dibit is ignored.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; axiov=0, axiod=0, busy=0, drop=0; counters and delay line cleared; CRC=32'hFFFF_FFFF. Mid-frame reset aborts the frame immediately, with no FCS or IFG.
- Registers: all outputs are registered.
- Delay line: 32-entry dibit shift register covers the 32-dibit preamble+SFD.
- Latency: input dibit accepted at cycle t appears on axiod at cycle t+33.
- States: IDLE, PREAMBLE, DATA, PAD, FCS, IFG.
- IDLE:
  - axiiv=1 → capture dibit, in_cnt=1, go PREAMBLE.
  - busy rises the next cycle.
- PREAMBLE:
  - 32 cycles, axiov=1.
  - axiod=2'b01 for 31 cycles, then 2'b11 on the 32nd cycle (7×0x55 + 0xD5, LSB first).
  - Input continues to be accepted into the delay line.
  - Then go DATA.
- DATA:
  - Emit the delay-line tail and increment out_cnt.
  - While input is open, accept dibits and increment in_cnt.
  - Input closes on the first cycle axiiv=0.
  - When out_cnt==in_cnt and input is closed: go PAD if out_cnt<MIN_FRAME_DIBITS, else FCS.
- PAD: emit 2'b00 until out_cnt==MIN_FRAME_DIBITS, then go FCS.
- CRC:
  - Covers every DATA and PAD dibit.
  - Reflected CRC-32, poly 0xEDB88320, init all-ones, 2-bit update per cycle.
  - bit 0 is processed before bit 1.
- FCS:
  - 16 cycles emitting ~crc LSB-first: dibit k = ~crc[2k+1:2k].
  - Then go IFG.
- IFG:
  - axiov=0, axiod=0 for IFG_DIBITS cycles.
  - Then go IDLE; busy falls on the IDLE cycle.
  - A new frame may start on the first IDLE cycle.
- Drop rules (each such cycle: dibit ignored, drop=1 for that cycle):
  - axiiv=1 after input closed (frame gap then resume).
  - axiiv=1 in PAD, FCS or IFG.
  - axiiv=1 when in_cnt==MAX_FRAME_DIBITS.
- Ignored dibits never affect CRC, counters or the delay line.
- Single-dibit frame (axiiv high one cycle): 32 preamble, 1 data, PAD to minimum, FCS, IFG.
- Counter widths: in_cnt/out_cnt 13 bits; IFG counter sized for IFG_DIBITS; no wrap is possible within limits.

Test Plan:
- Reset: hold rst=0 while driving axiiv=1 → axiov=0, busy=0, drop=0. Release → first frame starts only on the next axiiv rise.
- Preamble/latency: 240-dibit frame starting cycle t → axiov rises t+1; dibits 01×31, 11 at t+32; input dibit 0 on axiod at t+33; axiov=1 for exactly 32+240+16 cycles.
- CRC vector: MIN_FRAME_DIBITS=0, input ASCII "123456789" (36 dibits LSB-first) → FCS = 0xCBF43926, first FCS dibit 2'b10, last 2'b11.
- Padding: 10-dibit frame → 230 dibits of 00 after data, FCS over the padded 240 dibits matches the reference model, IFG 48 cycles.
- Drop/back-to-back: axiiv pulses 3 cycles during FCS → drop high 3 cycles, FCS unchanged. New frame on the first IDLE cycle after IFG → preamble the next cycle.
- Mid-frame reset/oversize: assert rst during DATA → axiov=0 immediately, state IDLE. 6060-dibit input → last 4 dibits dropped (drop=4 pulses), 6056 data dibits sent.

Source files
------------

// File: rtl/eth_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_framer
// Description : RMII transmit framer. Wraps a contiguous input dibit stream
//               with preamble/SFD, pads it to the minimum length, appends the
//               CRC-32 FCS, then holds the line idle for the inter-frame gap.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_framer #(
    parameter int MIN_FRAME_DIBITS = 240,
    parameter int MAX_FRAME_DIBITS = 6056,
    parameter int IFG_DIBITS       = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       busy,
    output logic       drop
);

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_PRE  = 3'd1;
    localparam logic [2:0] c_S_DATA = 3'd2;
    localparam logic [2:0] c_S_PAD  = 3'd3;
    localparam logic [2:0] c_S_FCS  = 3'd4;
    localparam logic [2:0] c_S_IFG  = 3'd5;

    localparam logic [12:0]        c_MIN      = 13'(MIN_FRAME_DIBITS);
    localparam logic [12:0]        c_MAX      = 13'(MAX_FRAME_DIBITS);
    localparam int                 c_IFG_W    = (IFG_DIBITS > 1) ? $clog2(IFG_DIBITS) : 1;
    localparam logic [c_IFG_W-1:0] c_IFG_LAST = c_IFG_W'(IFG_DIBITS - 1);
    localparam logic [31:0]        c_POLY     = 32'hEDB8_8320;

    logic [2:0]         r_state;
    logic [63:0]        r_dly;
    logic [12:0]        r_in_cnt;
    logic [12:0]        r_out_cnt;
    logic [4:0]         r_pre_cnt;
    logic [4:0]         r_fcs_cnt;
    logic [c_IFG_W-1:0] r_ifg_cnt;
    logic               r_in_open;
    logic               r_iv_prev;
    logic [31:0]        r_crc;
    logic               r_axiov;
    logic [1:0]         r_axiod;
    logic               r_busy;
    logic               r_drop;

    logic               w_in_live;
    logic               w_start;
    logic               w_accept;
    logic               w_drop;
    logic [1:0]         w_shift_in;
    logic [1:0]         w_tail;

    // Reflected CRC-32 advanced by one dibit, bit 0 first.
    function automatic logic [31:0] f_crc2(input logic [31:0] crc, input logic [1:0] d);
        logic [31:0] c;
        c = crc;
        for (int b = 0; b < 2; b++) begin
            c = (c >> 1) ^ ((c[0] ^ d[b]) ? c_POLY : 32'h0);
        end
        return c;
    endfunction

    // A frame only starts on a rising axiiv so a run held across reset or
    // the IFG is never picked up halfway through.
    assign w_in_live  = r_in_open && (r_state == c_S_PRE || r_state == c_S_DATA);
    assign w_start    = (r_state == c_S_IDLE) && axiiv && !r_iv_prev;
    assign w_accept   = axiiv && w_in_live && (r_in_cnt != c_MAX);
    assign w_drop     = axiiv && (r_state != c_S_IDLE) && !w_accept;
    assign w_shift_in = (w_start || w_accept) ? axiid : 2'b00;
    assign w_tail     = r_dly[63:62];

    // 32-dibit delay line covering the preamble; idle slots shift in zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dly <= '0;
        end else begin
            r_dly <= {r_dly[61:0], w_shift_in};
        end
    end

    // Frame sequencer; every output is loaded one cycle ahead of the wire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_S_IDLE;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_pre_cnt <= '0;
            r_fcs_cnt <= '0;
            r_ifg_cnt <= '0;
            r_in_open <= 1'b0;
            r_iv_prev <= 1'b1;
            r_crc     <= 32'hFFFF_FFFF;
            r_axiov   <= 1'b0;
            r_axiod   <= 2'b00;
            r_busy    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_iv_prev <= axiiv;
            r_drop    <= w_drop;
            if (w_accept) begin
                r_in_cnt <= r_in_cnt + 13'd1;
            end
            if (w_in_live && !axiiv) begin
                r_in_open <= 1'b0;
            end
            case (r_state)
                c_S_IDLE: begin
                    if (w_start) begin
                        r_state   <= c_S_PRE;
                        r_in_cnt  <= 13'd1;
                        r_in_open <= 1'b1;
                        r_out_cnt <= '0;
                        r_pre_cnt <= '0;
                        r_crc     <= 32'hFFFF_FFFF;
                        r_axiov   <= 1'b1;
                        r_axiod   <= 2'b01;
                        r_busy    <= 1'b1;
                    end
                end
                c_S_PRE: begin
                    r_pre_cnt <= r_pre_cnt + 5'd1;
                    if (r_pre_cnt == 5'd31) begin
                        r_axiod   <= w_tail;
                        r_out_cnt <= 13'd1;
                        r_crc     <= f_crc2(r_crc, w_tail);
                        r_state   <= c_S_DATA;
                    end else begin
                        r_axiod <= (r_pre_cnt == 5'd30) ? 2'b11 : 2'b01;
                    end
                end
                c_S_DATA, c_S_PAD: begin
                    // Counts can only meet once input has closed or hit the
                    // size cap, so equality alone marks the end of data.
                    if (r_state == c_S_DATA && r_out_cnt != r_in_cnt) begin
                        r_axiod   <= w_tail;
                        r_out_cnt <= r_out_cnt + 13'd1;
                        r_crc     <= f_crc2(r_crc, w_tail);
                    end else if (r_out_cnt < c_MIN) begin
                        r_axiod   <= 2'b00;
                        r_out_cnt <= r_out_cnt + 13'd1;
                        r_crc     <= f_crc2(r_crc, 2'b00);
                        r_state   <= c_S_PAD;
                    end else begin
                        r_axiod   <= ~r_crc[1:0];
                        r_fcs_cnt <= 5'd1;
                        r_state   <= c_S_FCS;
                    end
                end
                c_S_FCS: begin
                    if (r_fcs_cnt == 5'd16) begin
                        r_axiov   <= 1'b0;
                        r_axiod   <= 2'b00;
                        r_ifg_cnt <= '0;
                        r_state   <= c_S_IFG;
                    end else begin
                        r_axiod   <= ~r_crc[{r_fcs_cnt[3:0], 1'b0} +: 2];
                        r_fcs_cnt <= r_fcs_cnt + 5'd1;
                    end
                end
                c_S_IFG: begin
                    if (r_ifg_cnt == c_IFG_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= c_S_IDLE;
                    end else begin
                        r_ifg_cnt <= r_ifg_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign axiov = r_axiov;
    assign axiod = r_axiod;
    assign busy  = r_busy;
    assign drop  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_tx_framer
// Description : Scoreboard bench for eth_tx_framer. Stimulus pushes whole
//               expected frames; a negedge monitor pops and compares them and
//               checks the gap. Second instance runs with padding disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_tx_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       iv0 = 1'b0, iv1 = 1'b0;
    logic [1:0] d0 = 2'b00, d1 = 2'b00;
    logic       av0, av1, bz0, bz1, dr0, dr1;
    logic [1:0] ad0, ad1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [1:0] exp_q0[$];
    logic [1:0] exp_q1[$];
    int         len_q0[$];
    int         len_q1[$];
    logic [1:0] dq[$];

    int         drop_cnt[2];
    bit         in_frame[2];
    bit         gap_on[2];
    int         idx[2], exp_len[2], bad_idx[2], gap[2];
    logic [1:0] bad_act[2], bad_exp[2];

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eth_tx_framer u_dut0 (
        .clk(clk), .rst(rst), .axiiv(iv0), .axiid(d0),
        .axiov(av0), .axiod(ad0), .busy(bz0), .drop(dr0)
    );

    eth_tx_framer #(.MIN_FRAME_DIBITS(0)) u_dut1 (
        .clk(clk), .rst(rst), .axiiv(iv1), .axiid(d1),
        .axiov(av1), .axiod(ad1), .busy(bz1), .drop(dr1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int k, input logic [1:0] v);
        if (k == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    // Reference frame from dq: preamble/SFD, data, zero pad, FCS.
    task automatic push_frame(input int k, input int n, input int min_d,
                              input bit fix, input logic [31:0] fix_fcs);
        logic [31:0] c;
        logic [31:0] f;
        logic [1:0]  dib;
        logic        fb;
        int          tot;
        c   = 32'hFFFF_FFFF;
        tot = (n < min_d) ? min_d : n;
        for (int i = 0; i < 31; i++) push_exp(k, 2'b01);
        push_exp(k, 2'b11);
        for (int i = 0; i < tot; i++) begin
            dib = (i < n) ? dq[i] : 2'b00;
            push_exp(k, dib);
            for (int b = 0; b < 2; b++) begin
                fb = c[0] ^ dib[b];
                c  = (c >> 1) ^ (fb ? 32'hEDB8_8320 : 32'h0);
            end
        end
        f = fix ? fix_fcs : ~c;
        for (int j = 0; j < 16; j++) push_exp(k, f[2*j +: 2]);
        if (k == 0) len_q0.push_back(32 + tot + 16);
        else        len_q1.push_back(32 + tot + 16);
    endtask

    task automatic mon(input int k, input logic v, input logic [1:0] d, input logic b, input logic dr);
        logic [1:0] e;
        if (dr) drop_cnt[k]++;
        if (v) begin
            if (!in_frame[k]) begin
                in_frame[k] = 1'b1;
                gap_on[k]   = 1'b0;
                idx[k]      = 0;
                bad_idx[k]  = -1;
                if (k == 0 && len_q0.size() > 0)      exp_len[k] = len_q0.pop_front();
                else if (k == 1 && len_q1.size() > 0) exp_len[k] = len_q1.pop_front();
                else                                  exp_len[k] = -1;
            end
            e = 2'bxx;
            if (idx[k] < exp_len[k]) begin
                if (k == 0) e = exp_q0.pop_front();
                else        e = exp_q1.pop_front();
            end
            if (d !== e && bad_idx[k] < 0) begin
                bad_idx[k] = idx[k];
                bad_act[k] = d;
                bad_exp[k] = e;
            end
            idx[k]++;
        end else if (in_frame[k]) begin
            in_frame[k] = 1'b0;
            for (int i = idx[k]; i < exp_len[k]; i++) begin
                if (k == 0) e = exp_q0.pop_front();
                else        e = exp_q1.pop_front();
            end
            n_tests++;
            if (bad_idx[k] >= 0 || idx[k] != exp_len[k]) begin
                n_fail++;
                $display("FAIL frame%0d: length %0d expected %0d, first bad dibit %0d got %b expected %b",
                         k, idx[k], exp_len[k], bad_idx[k], bad_act[k], bad_exp[k]);
            end
            gap_on[k] = 1'b1;
            gap[k]    = 0;
        end
        if (gap_on[k] && !v) begin
            if (b) gap[k]++;
            else begin
                gap_on[k] = 1'b0;
                check($sformatf("ifg%0d", k), gap[k], 48);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                in_frame[k] = 1'b0;
                gap_on[k]   = 1'b0;
            end
        end else begin
            mon(0, av0, ad0, bz0, dr0);
            mon(1, av1, ad1, bz1, dr1);
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample_at(input int k, input int c, output logic v, output logic [1:0] d, output logic b);
        wait_cyc(c);
        @(negedge clk);
        v = (k == 0) ? av0 : av1;
        d = (k == 0) ? ad0 : ad1;
        b = (k == 0) ? bz0 : bz1;
    endtask

    task automatic drive_frame(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            if (k == 0) begin iv0 = 1'b1; d0 = dq[i]; end
            else        begin iv1 = 1'b1; d1 = dq[i]; end
            @(posedge clk);
            #1;
        end
        if (k == 0) begin iv0 = 1'b0; d0 = 2'b00; end
        else        begin iv1 = 1'b0; d1 = 2'b00; end
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (((k == 0) ? (bz0 || exp_q0.size() > 0) : (bz1 || exp_q1.size() > 0)) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 20000) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout%0d: still busy after %0d cycles", k, n);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input int seed);
        dq.delete();
        for (int i = 0; i < n; i++) dq.push_back(2'(i * seed + (i >> 2) + 2));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       v;
        logic [1:0] d;
        logic       b;
        logic [7:0] ch;
        string      s;
        int         t0;
        int         dc;
        int         lens[4];

        // Reset held with input active
        rst = 1'b0; iv0 = 1'b1; d0 = 2'b10;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_axiov", av0, 0);
        check("rst_busy",  bz0, 0);
        check("rst_drop",  dr0, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("held_axiov", av0, 0);
        check("held_busy",  bz0, 0);
        @(posedge clk); #1 iv0 = 1'b0; d0 = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        // Minimum-length frame: latency and preamble
        fill(240, 5);
        push_frame(0, 240, 240, 1'b0, 32'h0);
        t0 = cyc;
        fork
            drive_frame(0, 240);
            begin
                sample_at(0, t0, v, d, b);      check("lat_t_axiov", v, 0);
                sample_at(0, t0 + 1, v, d, b);  check("lat_t1_axiov", v, 1);
                check("lat_t1_busy", b, 1);
                sample_at(0, t0 + 32, v, d, b); check("sfd_dibit", d, 2'b11);
                sample_at(0, t0 + 33, v, d, b); check("first_data", d, dq[0]);
            end
        join
        wait_idle(0);

        // CRC check vector, padding disabled
        dq.delete();
        s = "123456789";
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            for (int j = 0; j < 4; j++) dq.push_back(ch[2*j +: 2]);
        end
        push_frame(1, 36, 0, 1'b1, 32'hCBF4_3926);
        t0 = cyc;
        fork
            drive_frame(1, 36);
            begin
                sample_at(1, t0 + 69, v, d, b); check("fcs_first", d, 2'b10);
                sample_at(1, t0 + 84, v, d, b); check("fcs_last",  d, 2'b11);
                sample_at(1, t0 + 85, v, d, b); check("fcs_end_axiov", v, 0);
            end
        join
        wait_idle(1);

        // Short frame padded, drops during FCS, then back-to-back start
        fill(10, 3);
        push_frame(0, 10, 240, 1'b0, 32'h0);
        t0 = cyc;
        dc = drop_cnt[0];
        fork
            drive_frame(0, 10);
            begin
                wait_cyc(t0 + 275); iv0 = 1'b1; d0 = 2'b11;
                wait_cyc(t0 + 278); iv0 = 1'b0; d0 = 2'b00;
            end
        join
        wait_cyc(t0 + 300);
        check("drop_in_fcs", drop_cnt[0] - dc, 3);
        fill(30, 7);
        push_frame(0, 30, 240, 1'b0, 32'h0);
        wait_cyc(t0 + 337);
        fork
            drive_frame(0, 30);
            begin
                sample_at(0, t0 + 337, v, d, b);
                check("b2b_idle_axiov", v, 0);
                check("b2b_idle_busy",  b, 0);
                sample_at(0, t0 + 338, v, d, b);
                check("b2b_preamble", v, 1);
            end
        join
        wait_idle(0);

        // Assorted lengths including a single-dibit frame
        lens = '{1, 239, 241, 300};
        for (int i = 0; i < 4; i++) begin
            fill(lens[i], i + 1);
            push_frame(0, lens[i], 240, 1'b0, 32'h0);
            drive_frame(0, lens[i]);
            wait_idle(0);
        end

        // Reset in the middle of the data phase
        fill(40, 6);
        push_frame(0, 40, 240, 1'b0, 32'h0);
        t0 = cyc;
        drive_frame(0, 40);
        wait_cyc(t0 + 50);
        rst = 1'b0;
        #1;
        check("mrst_axiov", av0, 0);
        check("mrst_busy",  bz0, 0);
        exp_q0.delete();
        len_q0.delete();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        fill(12, 2);
        push_frame(0, 12, 240, 1'b0, 32'h0);
        t0 = cyc;
        fork
            drive_frame(0, 12);
            begin
                sample_at(0, t0 + 1, v, d, b);
                check("post_rst_start", v, 1);
            end
        join
        wait_idle(0);

        // Oversize input: excess dibits dropped
        fill(6060, 3);
        push_frame(0, 6056, 240, 1'b0, 32'h0);
        dc = drop_cnt[0];
        drive_frame(0, 6060);
        wait_idle(0);
        check("oversize_drops", drop_cnt[0] - dc, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
